// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller: display modes
// and active-high segment patterns {a,b,c,d,e,f,g,dp}.
package seg_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Entry n is the pattern for hex digit n.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high segment pattern, with blanking
// and decimal point.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      pattern = SEG_HEX[nibble] | {7'b0, dp};
    end
  end

endmodule

// File: rtl/seg_disp_ctrl.sv
// N-digit registered seven-segment controller: buffered value, tick divider,
// static/blink/scroll/off modes, leading-zero blanking and output polarity.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 6,
  parameter int unsigned CLK_DIV    = 5000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_en,
  input  logic                  lz_en,
  input  logic [1:0]            mode,
  output logic [8*N_DIGITS-1:0] o_seg,
  output logic                  tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned OW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [OW-1:0] OFF_MAX = OW'(N_DIGITS - 1);
  localparam logic [8*N_DIGITS-1:0] SEG_ALL_OFF = ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [OW-1:0]         offset_q, offset_d;
  logic [4*N_DIGITS-1:0] buf_q, buf_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d;
  logic                  lz_q, lz_d;
  logic                  tick_q, tick_d;
  mode_e                 mode_q, mode_d;
  logic [8*N_DIGITS-1:0] seg_q, seg_d;

  logic [N_DIGITS-1:0]   lz_blank;
  logic [4*N_DIGITS-1:0] dig_nib;
  logic [N_DIGITS-1:0]   dig_blank;
  logic [N_DIGITS-1:0]   dig_dp;
  logic [8*N_DIGITS-1:0] dig_pat;

  // tick_q is high exactly while cnt_q sits at CNT_MAX, so it doubles as the
  // wrap flag. Phase and offset advance in every mode and are masked on
  // display; entering a mode always clears them, so the result is the same.
  always_comb begin
    buf_d = buf_q;
    dp_d  = dp_q;
    lz_d  = lz_q;
    if (load) begin
      buf_d = value;
      dp_d  = dp_en;
      lz_d  = lz_en;
    end
    mode_d   = mode_e'(mode);
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    phase_d  = phase_q ^ tick_q;
    offset_d = offset_q;
    if (tick_q) begin
      offset_d = (offset_q == OFF_MAX) ? '0 : offset_q + 1'b1;
    end
    if (mode_d != mode_q) begin
      cnt_d    = '0;
      phase_d  = 1'b0;
      offset_d = '0;
    end
    tick_d = (cnt_d == CNT_MAX);
  end

  always_comb begin
    logic        seen;
    logic        all_blank;
    logic [OW-1:0] rot;
    int unsigned j;
    seen     = 1'b0;
    lz_blank = '0;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      seen        = seen | (buf_q[4*k +: 4] != 4'h0);
      lz_blank[k] = lz_q & ~seen;
    end
    all_blank = (mode_q == MODE_OFF) || ((mode_q == MODE_BLINK) && phase_q);
    rot       = (mode_q == MODE_SCROLL) ? offset_q : '0;
    dig_nib   = '0;
    dig_blank = '0;
    dig_dp    = dp_q;
    j         = 0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      j = i + 32'(rot);
      if (j >= N_DIGITS) j = j - N_DIGITS;
      dig_nib[4*i +: 4] = buf_q[4*j +: 4];
      dig_blank[i]      = all_blank | lz_blank[j];
    end
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
    seg_hex_decode u_dec (
      .nibble  (dig_nib[4*g +: 4]),
      .blank   (dig_blank[g]),
      .dp      (dig_dp[g]),
      .pattern (dig_pat[8*g +: 8])
    );
  end

  always_comb begin
    seg_d = ACTIVE_LOW ? ~dig_pat : dig_pat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      offset_q <= '0;
      buf_q    <= '0;
      dp_q     <= '0;
      lz_q     <= 1'b0;
      tick_q   <= 1'b0;
      mode_q   <= mode_e'(mode);
      seg_q    <= SEG_ALL_OFF;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      offset_q <= offset_d;
      buf_q    <= buf_d;
      dp_q     <= dp_d;
      lz_q     <= lz_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
      seg_q    <= seg_d;
    end
  end

  assign o_seg = seg_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl (6 digits, divide-by-4, active-low):
// vector table, directed multi-cycle sequences and a random run vs a model.
module tb_seg_disp_ctrl;

  localparam int N   = 6;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst, load, lz_en;
  logic [23:0] value;
  logic [5:0]  dp_en;
  logic [1:0]  mode;
  logic [47:0] o_seg;
  logic        tick;

  always #5 clk = ~clk;

  seg_disp_ctrl #(.N_DIGITS(N), .CLK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_en(dp_en),
    .lz_en(lz_en), .mode(mode), .o_seg(o_seg), .tick(tick)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] hexpat [16];
  logic [7:0] dig_inv [6];

  logic [23:0] m_buf;
  logic [5:0]  m_dp;
  bit          m_lz;
  int          m_cnt, m_phase, m_off, m_mode;
  logic [47:0] m_seg;
  bit          m_tick;
  bit          m_valid = 1'b0;

  typedef struct {
    logic [23:0] v;
    logic [5:0]  dp;
    logic        lz;
    logic [1:0]  md;
    logic [47:0] exp;
  } vec_t;
  vec_t vecs [9];

  // Display as the spec describes it: rotation, blanking rules, dp, polarity.
  function automatic logic [47:0] ref_disp(input logic [23:0] b, input logic [5:0] dp,
                                           input bit lz, input int md, input int ph,
                                           input int off);
    logic [47:0] r;
    logic [23:0] hi;
    logic [7:0]  p;
    int          j;
    bit          bl;
    r = '0;
    for (int i = 0; i < N; i++) begin
      j  = (md == 2) ? (i + off) % N : i;
      hi = b >> (4 * j);
      bl = (md == 3) || (md == 1 && ph == 1) || (lz && j != 0 && hi == 0);
      p  = bl ? 8'h00 : (hexpat[hi[3:0]] | {7'b0, dp[i]});
      r[8*i +: 8] = ~p;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    bit tick_now;
    if (rst) begin
      m_buf = '0; m_dp = '0; m_lz = 0;
      m_cnt = 0; m_phase = 0; m_off = 0; m_mode = int'(mode);
      m_seg = '1; m_tick = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_seg    = ref_disp(m_buf, m_dp, m_lz, m_mode, m_phase, m_off);
      tick_now = (m_cnt == DIV - 1);
      if (load) begin
        m_buf = value; m_dp = dp_en; m_lz = lz_en;
      end
      if (int'(mode) != m_mode) begin
        m_cnt = 0; m_phase = 0; m_off = 0;
      end else begin
        m_cnt = (m_cnt + 1) % DIV;
        if (tick_now) begin
          m_phase = 1 - m_phase;
          m_off   = (m_off + 1) % N;
        end
      end
      m_mode = int'(mode);
      m_tick = (m_cnt == DIV - 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (m_valid) begin
      chk("model_seg", o_seg, m_seg);
      chk("model_tick", {47'b0, tick}, {47'b0, m_tick});
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * DIV && !tick; i++) step();
    if (!tick) chk("tick_timeout", {47'b0, tick}, 48'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hexpat = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    dig_inv = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49};
    vecs[0] = '{24'h12A4F0, 6'b000000, 1'b0, 2'd0, 48'h9F2511997103};
    vecs[1] = '{24'h0000A0, 6'b000000, 1'b1, 2'd0, 48'hFFFFFFFF1103};
    vecs[2] = '{24'h000000, 6'b000000, 1'b1, 2'd0, 48'hFFFFFFFFFF03};
    vecs[3] = '{24'h000000, 6'b000001, 1'b0, 2'd0, 48'h030303030302};
    vecs[4] = '{24'h0000A0, 6'b100001, 1'b1, 2'd0, 48'hFFFFFFFF1102};
    vecs[5] = '{24'h89BCDE, 6'b000000, 1'b0, 2'd0, 48'h0109C1638561};
    vecs[6] = '{24'h005670, 6'b000000, 1'b1, 2'd0, 48'hFFFF49411F03};
    vecs[7] = '{24'h800000, 6'b000000, 1'b1, 2'd0, 48'h010303030303};
    vecs[8] = '{24'h123456, 6'b111111, 1'b0, 2'd3, 48'hFFFFFFFFFFFF};

    rst = 1'b1; load = 1'b0; value = '0; dp_en = '0; lz_en = 1'b0; mode = 2'd0;
    step(); step();
    chk("reset_seg", o_seg, 48'hFFFFFFFFFFFF);
    chk("reset_tick", {47'b0, tick}, 48'd0);
    rst = 1'b0;

    // Table vectors: load, then result visible one edge after the buffer update.
    for (int v = 0; v < 9; v++) begin
      value = vecs[v].v; dp_en = vecs[v].dp; lz_en = vecs[v].lz; mode = vecs[v].md;
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk($sformatf("vec%0d", v), o_seg, vecs[v].exp);
    end

    // Blink: 4 cycles shown, 4 cycles blank; tick every 4th cycle.
    value = 24'h12A4F0; dp_en = '0; lz_en = 1'b0; mode = 2'd1; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("blink_seg%0d", k), o_seg,
          (((k - 1) / 4) % 2 == 1) ? 48'hFFFFFFFFFFFF : 48'h9F2511997103);
      chk($sformatf("blink_tick%0d", k), {47'b0, tick}, {47'b0, (k % 4) == 3});
    end

    // Scroll: digit0 walks 0,1,2,3,4,5,0.
    value = 24'h543210; mode = 2'd2; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      step();
      chk($sformatf("scroll_d0_%0d", k), {40'b0, o_seg[7:0]},
          {40'b0, dig_inv[((k - 1) / 4) % 6]});
    end

    // Load coincident with tick in scroll mode.
    wait_tick();
    value = 24'hFFFFFF; load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("load_at_tick", o_seg, 48'h717171717171);

    // Scroll -> static mid-count: static view next cycle, divider restarts.
    value = 24'h543210; load = 1'b1;
    step();
    load = 1'b0;
    step(); step();
    mode = 2'd0;
    step();
    step();
    chk("scroll_to_static", o_seg, 48'h49990D259F03);
    chk("restart_tick1", {47'b0, tick}, 48'd0);
    step();
    chk("restart_tick2", {47'b0, tick}, 48'd0);
    step();
    chk("restart_tick3", {47'b0, tick}, 48'd1);

    // Reset in the middle of scrolling with dp on digit 0.
    mode = 2'd2; dp_en = 6'b000001; value = 24'h543210; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("dp_before_rst", {47'b0, o_seg[0]}, 48'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_seg", o_seg, 48'hFFFFFFFFFFFF);
    chk("mid_rst_tick", {47'b0, tick}, 48'd0);
    rst = 1'b0;
    step();
    chk("after_rst_seg", o_seg, 48'h030303030303);

    // Random run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 3) == 0);
      value = 24'($urandom >> $urandom_range(0, 24));
      dp_en = 6'($urandom);
      lz_en = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
